// File: rtl/decoder_seq_if.sv
// Command/status bundle between a scan controller and the decoder address sequencer.
// The master issues scan commands; the slave (sequencer) drives the decoder address.
interface decoder_seq_if #(
  parameter int ADDR_W  = 4,
  parameter int DWELL_W = 4
);
  logic              start_valid;
  logic              start_ready;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   count;
  logic              dir;
  logic [DWELL_W-1:0] dwell;
  logic              abort;
  logic [ADDR_W-1:0] A;
  logic              a_valid;
  logic              busy;
  logic              done;
  logic              last;

  modport master (
    output start_valid, start_addr, count, dir, dwell, abort,
    input  start_ready, A, a_valid, busy, done, last
  );

  modport slave (
    input  start_valid, start_addr, count, dir, dwell, abort,
    output start_ready, A, a_valid, busy, done, last
  );
endinterface

// File: rtl/decoder_seq.sv
// Address sequencer feeding a 4-to-16 row decoder: walks A through a modulo-16 range,
// holding each address dwell+1 cycles, with a one-cycle done pulse and abort.
module decoder_seq #(
  parameter int DWELL_W = 4,
  parameter int ADDR_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  decoder_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [ADDR_W:0]    remaining_reg, remaining_next;
  logic               dir_reg, dir_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic [DWELL_W-1:0] dwell_cnt_reg, dwell_cnt_next;

  logic               accept;
  logic [ADDR_W-1:0]  addr_step;

  assign accept    = (state_reg == IDLE) && bus.start_valid;
  // Natural ADDR_W-bit wrap gives 15+1=0 and 0-1=15 without extra logic.
  assign addr_step = dir_reg ? (addr_reg - 1'b1) : (addr_reg + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      dir_reg       <= 1'b0;
      dwell_reg     <= '0;
      dwell_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      dir_reg       <= dir_next;
      dwell_reg     <= dwell_next;
      dwell_cnt_reg <= dwell_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    dir_next       = dir_reg;
    dwell_next     = dwell_reg;
    dwell_cnt_next = dwell_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          remaining_next = bus.count;
          dir_next       = bus.dir;
          dwell_next     = bus.dwell;
          dwell_cnt_next = bus.dwell;
          if (bus.count == '0) begin
            // Empty scan: A keeps its previous value and only done is reported.
            state_next = DONE;
          end else begin
            addr_next  = bus.start_addr;
            state_next = RUN;
          end
        end
      end

      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (dwell_cnt_reg == '0) begin
          if (remaining_reg > 1) begin
            addr_next      = addr_step;
            remaining_next = remaining_reg - 1'b1;
            dwell_cnt_next = dwell_reg;
          end else begin
            state_next = DONE;
          end
        end else begin
          dwell_cnt_next = dwell_cnt_reg - 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status is decoded straight from the state register so reset clears it at once.
  assign bus.A           = addr_reg;
  assign bus.start_ready = (state_reg == IDLE);
  assign bus.a_valid     = (state_reg == RUN);
  assign bus.busy        = (state_reg == RUN);
  assign bus.done        = (state_reg == DONE);
  assign bus.last        = (state_reg == RUN) && (remaining_reg == 1);

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: directed and random scans compared cycle by cycle
// against a per-cycle trace computed from the scan arithmetic.
module tb_decoder_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  decoder_seq_if #(.ADDR_W(4), .DWELL_W(4)) bus ();

  decoder_seq #(.DWELL_W(4), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int scan_id = 0;
  logic [3:0] last_a = 4'd0;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {A, a_valid, busy, last, done, start_ready}
  function automatic logic [8:0] pk(input logic [3:0] a, input logic v, input logic b,
                                    input logic l, input logic dn, input logic r);
    return {a, v, b, l, dn, r};
  endfunction

  function automatic logic [8:0] outs();
    return {bus.A, bus.a_valid, bus.busy, bus.last, bus.done, bus.start_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.start_addr = 4'($urandom_range(0, 15));
    bus.count      = 5'($urandom_range(0, 16));
    bus.dir        = 1'($urandom_range(0, 1));
    bus.dwell      = 4'($urandom_range(0, 15));
  endtask

  // abort_at: RUN cycle index (1-based) during which abort is raised, 0 = none.
  // odd_abort: raise abort in the accept (IDLE) and DONE cycles, where it must be ignored.
  task automatic run_scan(input int a0, input int n, input bit d, input int dw,
                          input int abort_at, input bit odd_abort, input bit check_visits);
    int len;
    int idx;
    int e;
    bit aborted;
    logic [3:0] ea;
    int visits [16];
    len = n * (dw + 1);
    aborted = 1'b0;
    for (int i = 0; i < 16; i++) visits[i] = 0;
    scan_id++;

    chk($sformatf("scan%0d ready_pre", scan_id), outs(), pk(last_a, 0, 0, 0, 0, 1));
    bus.start_valid = 1'b1;
    bus.start_addr  = 4'(a0);
    bus.count       = 5'(n);
    bus.dir         = d;
    bus.dwell       = 4'(dw);
    bus.abort       = odd_abort;
    tick();
    bus.abort = 1'b0;
    // start_valid stays high with new fields: must be ignored while the scan runs.
    scramble();

    for (int k = 1; k <= len; k++) begin
      idx = (k - 1) / (dw + 1);
      e = (a0 + (d ? (16 - (idx % 16)) : idx)) % 16;
      ea = 4'(e);
      chk($sformatf("scan%0d run k%0d", scan_id, k), outs(),
          pk(ea, 1, 1, (idx == n - 1), 0, 0));
      if (check_visits && ((k - 1) % (dw + 1) == 0)) visits[bus.A]++;
      last_a = ea;
      if (abort_at == k) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start_valid = 1'b0;
        chk($sformatf("scan%0d aborted", scan_id), outs(), pk(last_a, 0, 0, 0, 0, 1));
        aborted = 1'b1;
        break;
      end
      tick();
    end

    if (!aborted) begin
      chk($sformatf("scan%0d done", scan_id), outs(), pk(last_a, 0, 0, 0, 1, 0));
      bus.start_valid = 1'b0;
      bus.abort = odd_abort;
      tick();
      bus.abort = 1'b0;
      chk($sformatf("scan%0d idle", scan_id), outs(), pk(last_a, 0, 0, 0, 0, 1));
    end

    if (check_visits) begin
      for (int i = 0; i < 16; i++)
        chk($sformatf("scan%0d visit%0d", scan_id, i), 9'(visits[i]), 9'd1);
    end

    $display("scan %0d: start=%0d count=%0d dir=%0d dwell=%0d abort_at=%0d -> A=%0d",
             scan_id, a0, n, d, dw, abort_at, last_a);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int n;
    int dw;
    int ab;
    bit d;

    bus.start_valid = 1'b0;
    bus.abort       = 1'b0;
    bus.start_addr  = '0;
    bus.count       = '0;
    bus.dir         = 1'b0;
    bus.dwell       = '0;

    #12;
    chk("reset_state", outs(), pk(4'd0, 0, 0, 0, 0, 1));
    rst_n = 1'b1;
    tick();
    chk("post_reset", outs(), pk(4'd0, 0, 0, 0, 0, 1));

    // Directed cases
    run_scan(3, 4, 0, 0, 0, 0, 0);
    run_scan(14, 4, 0, 0, 0, 0, 0);
    run_scan(1, 3, 1, 0, 0, 0, 0);
    run_scan(0, 2, 0, 2, 0, 0, 0);
    run_scan(5, 16, 0, 0, 0, 0, 1);
    run_scan(9, 16, 1, 1, 0, 1, 1);
    run_scan(7, 5, 0, 0, 2, 0, 0);
    run_scan(2, 3, 1, 0, 3, 0, 0);
    run_scan(4, 2, 0, 3, 8, 1, 0);
    run_scan(11, 0, 0, 0, 0, 1, 0);

    // Asynchronous reset in the middle of a scan
    bus.start_valid = 1'b1;
    bus.start_addr  = 4'd6;
    bus.count       = 5'd8;
    bus.dir         = 1'b0;
    bus.dwell       = 4'd1;
    tick();
    bus.start_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_reset_run", outs(), pk(4'd7, 1, 1, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), pk(4'd0, 0, 0, 0, 0, 1));
    tick();
    chk("reset_held", outs(), pk(4'd0, 0, 0, 0, 0, 1));
    #3;
    rst_n = 1'b1;
    tick();
    chk("reset_release", outs(), pk(4'd0, 0, 0, 0, 0, 1));
    last_a = 4'd0;

    // Random scans
    for (int i = 0; i < 24; i++) begin
      a0 = $urandom_range(0, 15);
      n  = $urandom_range(0, 16);
      d  = 1'($urandom_range(0, 1));
      dw = $urandom_range(0, 3);
      ab = 0;
      if (n > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, n * (dw + 1));
      run_scan(a0, n, d, dw, ab, 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
